fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//   Select generator for the EX-stage operand forwarding muxes (3:1, SEL 0=regfile, 1=WB data, 2=MEM ALU result).
//   Keeps a shadow of the destination fields for the EX/MEM/WB stages, computes registered forward selects,
//   and detects load-use / RAW hazards, issuing stall and bubble control to PC, IF/ID and ID/EX.
//   Sits beside the ID/EX pipeline register; its outputs drive the operand muxes and the pipeline-register enables.
// PARAMETERS
//   REG_ADDR_W   5   register-address width
//   LOAD_STALL   1   bubbles inserted on a load-use hazard with forwarding enabled; legal range 1..3
// PORTS
//   CLK          in   1            clock; all state updates on rising edge
//   RESET        in   1            synchronous, active-high reset
//   ID_Valid     in   1            ID stage holds a real instruction
//   ID_Rs        in   REG_ADDR_W   source register A of the ID instruction
//   ID_Rt        in   REG_ADDR_W   source register B of the ID instruction
//   ID_Rd        in   REG_ADDR_W   resolved destination register of the ID instruction
//   ID_RegWrite  in   1            ID instruction writes the register file
//   ID_MemRead   in   1            ID instruction is a load
//   Flush        in   1            taken branch/jump: kill the ID instruction
//   FwdA_SEL     out  2            operand-A mux select for the instruction now in EX
//   FwdB_SEL     out  2            operand-B mux select for the instruction now in EX
//   Stall        out  1            hold PC and IF/ID (combinational)
//   Bubble       out  1            zero ID/EX control this cycle (combinational; = Stall | Flush)
// BEHAVIOUR
//   - Shadow regs: ex{rd,we,mr}, mem{rd,we}, wb{rd,we}. Every edge: wb<=mem, mem<=ex; ex<=ID fields on advance, else bubble (we=mr=0).
//   - Advance = ID_Valid & ~Stall & ~Flush. Writes to register 0 never match (rd==0 treated as we=0).
//   - Reset: all shadow regs 0, FwdA_SEL=FwdB_SEL=2'd0, state RUN, counter 0; Stall=0 and Bubble=0 at the following cycle unless inputs demand otherwise.
//   - Forward select (registered, written on advance; 2'd0 on bubble), per source src in {Rs,Rt}:
//       2'd2 if ex.we & ex.rd==src & ~ex.mr (producer moves to MEM); else 2'd1 if mem.we & mem.rd==src (moves to WB); else 2'd0.
//       EX match has priority over MEM match. Latency: select valid the cycle the consumer sits in EX. 2'd3 never driven.
//   - Hazard (combinational, RUN state, ID_Valid): load-use = ex.we & ex.mr & ex.rd in {ID_Rs,ID_Rt}.
//   - FSM RUN/STALL with counter cnt (2 bits):
//       RUN: hazard & ~Flush -> Stall=1, cnt<=N-1, go STALL if N>1 else stay RUN (re-evaluated next cycle).
//       STALL: Stall=1, cnt<=cnt-1; cnt==0 -> RUN. Shadow pipeline keeps shifting (bubbles enter EX).
//   - Flush: ex<=bubble, FwdSELs<=0, state<=RUN, cnt<=0; Stall=0 that cycle. Flush beats stall on the same edge.
//   - RESET mid-stall: immediate return to RUN, counter 0; RESET beats Flush and hazard.
//   - ID_Valid=0: no hazard, no advance, ex<=bubble.
// CONFIGURATION
//   FORWARDING_EN defined: behaviour above; load-use N=LOAD_STALL.
//   FORWARDING_EN undefined: FwdA_SEL/FwdB_SEL held at 2'd0; any RAW on ex (any we) gives N=2,
//     on mem only gives N=1; EX match takes precedence. Regfile is write-before-read, so WB needs no stall.
// TESTING
//   T1 reset: RESET=1 two cycles mid-stall -> Stall=0, FwdA_SEL=FwdB_SEL=0, state RUN next cycle.
//   T2 add r3 then add r4,r3,r3 back-to-back -> consumer in EX sees FwdA_SEL=FwdB_SEL=2, no stall.
//   T3 add r5; nop; sub r6,r1,r5 -> FwdB_SEL=1; same with rd=r0 -> FwdB_SEL=0.
//   T4 lw r7 then add r8,r7,r2, LOAD_STALL=1 -> Stall=Bubble=1 one cycle, then consumer EX with FwdA_SEL=1.
//   T5 load-use hazard with Flush=1 same cycle -> Stall=0, Bubble=1, next FwdSELs=0, state RUN.
//   T6 FORWARDING_EN undefined, add r3 then use r3 -> Stall=1 exactly 2 cycles, FwdSELs stay 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// Interface between the ID/EX stage logic and the forwarding / hazard controller.
// The pipeline side (master) presents the decoded ID instruction and the flush
// request; the controller side (slave) returns operand-mux selects and the
// stall/bubble enables.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  ID_Valid;
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic [REG_ADDR_W-1:0] ID_Rd;
    logic                  ID_RegWrite;
    logic                  ID_MemRead;
    logic                  Flush;
    logic [1:0]            FwdA_SEL;
    logic [1:0]            FwdB_SEL;
    logic                  Stall;
    logic                  Bubble;

    modport master (
        output ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_RegWrite, ID_MemRead, Flush,
        input  FwdA_SEL, FwdB_SEL, Stall, Bubble
    );

    modport slave (
        input  ID_Valid, ID_Rs, ID_Rt, ID_Rd, ID_RegWrite, ID_MemRead, Flush,
        output FwdA_SEL, FwdB_SEL, Stall, Bubble
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select generator and RAW / load-use hazard controller for the EX stage.
// Tracks a shadow copy of the destination fields of the EX, MEM and WB stages,
// registers the operand-mux selects for the instruction entering EX, and drives
// the stall (PC, IF/ID hold) and bubble (ID/EX zero) enables.
//
// Build option: define FORWARDING_EN to enable operand forwarding. Without it
// the selects stay at the register file and every RAW on EX or MEM stalls
// (2 cycles for an EX producer, 1 cycle for a MEM producer).
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_STALL = 1
) (
    input logic             CLK,
    input logic             RESET,
    fwd_hazard_ctrl_if.slave bus
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Extra stall cycles owed after the detecting cycle for a load-use hazard.
    localparam logic [1:0] LOAD_CNT = 2'(LOAD_STALL - 1);

    state_t                state_reg;
    logic [1:0]            cnt_reg;

    logic [REG_ADDR_W-1:0] ex_rd_reg;
    logic                  ex_we_reg;
    logic                  ex_mr_reg;
    logic [REG_ADDR_W-1:0] mem_rd_reg;
    logic                  mem_we_reg;
    logic [REG_ADDR_W-1:0] wb_rd_reg;
    logic                  wb_we_reg;

    logic [1:0]            fwd_a_reg;
    logic [1:0]            fwd_b_reg;

    logic [REG_ADDR_W-1:0] src [2];
    logic [1:0]            ex_hit;
    logic [1:0]            mem_hit;
    logic [1:0]            sel_next [2];

    logic                  hazard;
    logic [1:0]            hazard_cnt;
    logic                  run_hazard;
    logic                  stall_now;
    logic                  advance;

    // WB shadow is kept for visibility only: the register file writes before it
    // reads, so a WB producer never needs a stall or a forward.
    logic                  unused_state;
    assign unused_state = ^{wb_rd_reg, wb_we_reg, ex_mr_reg, LOAD_CNT};

    assign src[0] = bus.ID_Rs;
    assign src[1] = bus.ID_Rt;

    // Per-source comparison against the EX and MEM producers.
    // The shadow write-enables already exclude register 0.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign ex_hit[gi]  = ex_we_reg  & (ex_rd_reg  == src[gi]);
            assign mem_hit[gi] = mem_we_reg & (mem_rd_reg == src[gi]);
`ifdef FORWARDING_EN
            // EX producer moves to MEM (ALU result path) unless it is a load;
            // a MEM producer moves to WB (writeback data path).
            assign sel_next[gi] = (ex_hit[gi] & ~ex_mr_reg) ? 2'd2 :
                                  mem_hit[gi]               ? 2'd1 : 2'd0;
`else
            assign sel_next[gi] = 2'd0;
`endif
        end
    endgenerate

`ifdef FORWARDING_EN
    // Only a load sitting in EX cannot be forwarded in time.
    assign hazard     = (|ex_hit) & ex_mr_reg;
    assign hazard_cnt = LOAD_CNT;
`else
    // Any RAW on EX or MEM must wait for the producer to reach WB.
    assign hazard     = (|ex_hit) | (|mem_hit);
    assign hazard_cnt = (|ex_hit) ? 2'd1 : 2'd0;
`endif

    // Stall/bubble are combinational; Flush always wins over a stall.
    assign run_hazard = (state_reg == ST_RUN) & bus.ID_Valid & hazard;
    assign stall_now  = ~bus.Flush & ((state_reg == ST_STALL) | run_hazard);
    assign advance    = bus.ID_Valid & ~stall_now & ~bus.Flush;

    assign bus.Stall    = stall_now;
    assign bus.Bubble   = stall_now | bus.Flush;
    assign bus.FwdA_SEL = fwd_a_reg;
    assign bus.FwdB_SEL = fwd_b_reg;

    // Shadow pipeline: shifts every cycle; EX takes the ID fields only on advance.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_rd_reg  <= '0;
            ex_we_reg  <= 1'b0;
            ex_mr_reg  <= 1'b0;
            mem_rd_reg <= '0;
            mem_we_reg <= 1'b0;
            wb_rd_reg  <= '0;
            wb_we_reg  <= 1'b0;
        end else begin
            wb_rd_reg  <= mem_rd_reg;
            wb_we_reg  <= mem_we_reg;
            mem_rd_reg <= ex_rd_reg;
            mem_we_reg <= ex_we_reg;
            if (advance) begin
                ex_rd_reg <= bus.ID_Rd;
                ex_we_reg <= bus.ID_RegWrite & (bus.ID_Rd != '0);
                ex_mr_reg <= bus.ID_MemRead;
            end else begin
                ex_rd_reg <= '0;
                ex_we_reg <= 1'b0;
                ex_mr_reg <= 1'b0;
            end
        end
    end

    // Stall sequencer: RUN detects a hazard, STALL counts out the remaining cycles.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 2'd0;
        end else if (bus.Flush) begin
            state_reg <= ST_RUN;
            cnt_reg   <= 2'd0;
        end else if (state_reg == ST_STALL) begin
            if (cnt_reg <= 2'd1) begin
                cnt_reg   <= 2'd0;
                state_reg <= ST_RUN;
            end else begin
                cnt_reg <= cnt_reg - 2'd1;
            end
        end else if (run_hazard) begin
            cnt_reg   <= hazard_cnt;
            state_reg <= (hazard_cnt != 2'd0) ? ST_STALL : ST_RUN;
        end
    end

    // Registered forward selects, valid while the consumer sits in EX.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fwd_a_reg <= 2'd0;
            fwd_b_reg <= 2'd0;
        end else if (advance) begin
            fwd_a_reg <= sel_next[0];
            fwd_b_reg <= sel_next[1];
        end else begin
            fwd_a_reg <= 2'd0;
            fwd_b_reg <= 2'd0;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed scenarios with literal expectations,
// then randomized instruction streams checked every cycle against a
// stage-list model of the pipeline. Follows the FORWARDING_EN build option.
module tb_fwd_hazard_ctrl;
    localparam int AW         = 5;
    localparam int LOAD_STALL = 1;
`ifdef FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_ADDR_W(AW)) bus ();

    fwd_hazard_ctrl #(
        .REG_ADDR_W(AW),
        .LOAD_STALL(LOAD_STALL)
    ) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    typedef struct packed {
        logic          wr;
        logic          ld;
        logic [AW-1:0] rd;
    } slot_t;

    slot_t      m_ex, m_mem, m_wb;
    int         m_hold;      // stall cycles still owed after the current one
    logic [1:0] m_fa, m_fb;
    bit         started = 1'b0;

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic bit writes(slot_t s, logic [AW-1:0] r);
        return s.wr && (s.rd != '0) && (s.rd == r);
    endfunction

    function automatic logic [1:0] fwd_for(slot_t ex, slot_t mem, logic [AW-1:0] r);
        logic [1:0] s;
        s = 2'd0;
        if (writes(mem, r)) s = 2'd1;
        if (writes(ex, r) && !ex.ld) s = 2'd2;
        return FWD_EN ? s : 2'd0;
    endfunction

    // Total stall cycles an ID instruction with sources rs/rt needs right now.
    function automatic int stall_need(slot_t ex, slot_t mem, logic [AW-1:0] rs, logic [AW-1:0] rt);
        bit ex_raw, mem_raw;
        ex_raw  = writes(ex, rs) || writes(ex, rt);
        mem_raw = writes(mem, rs) || writes(mem, rt);
        if (FWD_EN) return (ex_raw && ex.ld) ? LOAD_STALL : 0;
        if (ex_raw) return 2;
        if (mem_raw) return 1;
        return 0;
    endfunction

    // Compare process: mid-cycle check of every output against the model,
    // then advance the model with the inputs the next rising edge will see.
    initial begin
        int         need;
        bit         owed, exp_stall, adv;
        logic [1:0] na, nb;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ex = '0; m_mem = '0; m_wb = '0;
                m_hold = 0; m_fa = 2'd0; m_fb = 2'd0;
                started = 1'b1;
            end else if (started) begin
                owed      = (m_hold > 0);
                need      = (!owed && bus.ID_Valid) ? stall_need(m_ex, m_mem, bus.ID_Rs, bus.ID_Rt) : 0;
                exp_stall = !bus.Flush && (owed || need > 0);
                check("model_stall",  {1'b0, bus.Stall},  {1'b0, exp_stall});
                check("model_bubble", {1'b0, bus.Bubble}, {1'b0, exp_stall || bus.Flush});
                check("model_fwd_a",  bus.FwdA_SEL, m_fa);
                check("model_fwd_b",  bus.FwdB_SEL, m_fb);
                adv = bus.ID_Valid && !exp_stall && !bus.Flush;
                na  = adv ? fwd_for(m_ex, m_mem, bus.ID_Rs) : 2'd0;
                nb  = adv ? fwd_for(m_ex, m_mem, bus.ID_Rt) : 2'd0;
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = adv ? slot_t'{wr: bus.ID_RegWrite, ld: bus.ID_MemRead, rd: bus.ID_Rd} : '0;
                m_fa  = na;
                m_fb  = nb;
                if (bus.Flush) m_hold = 0;
                else if (owed) m_hold = m_hold - 1;
                else if (need > 0) m_hold = need - 1;
            end
        end
    end

    // One clock: drive inputs just after the edge, let outputs settle, log it.
    task automatic cyc(input logic r, input logic v, input int rs, input int rt, input int rd,
                       input logic rw, input logic mr, input logic fl);
        @(posedge clk);
        #1;
        rst             = r;
        bus.ID_Valid    = v;
        bus.ID_Rs       = AW'(rs);
        bus.ID_Rt       = AW'(rt);
        bus.ID_Rd       = AW'(rd);
        bus.ID_RegWrite = rw;
        bus.ID_MemRead  = mr;
        bus.Flush       = fl;
        #1;
        txn++;
        $display("txn %0d rst=%0b v=%0b rs=%0d rt=%0d rd=%0d rw=%0b mr=%0b fl=%0b -> stall=%0b bubble=%0b fa=%0d fb=%0d",
                 txn, r, v, rs, rt, rd, rw, mr, fl, bus.Stall, bus.Bubble, bus.FwdA_SEL, bus.FwdB_SEL);
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.ID_Valid = 1'b0; bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_Rd = '0;
        bus.ID_RegWrite = 1'b0; bus.ID_MemRead = 1'b0; bus.Flush = 1'b0;
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        nop();
        check("reset_stall",  {1'b0, bus.Stall},  2'd0);
        check("reset_bubble", {1'b0, bus.Bubble}, 2'd0);
        check("reset_fwd_a",  bus.FwdA_SEL, 2'd0);
        check("reset_fwd_b",  bus.FwdB_SEL, 2'd0);

        // add r3,r1,r2 ; add r4,r3,r3
        nop(); nop();
        cyc(1'b0, 1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0);
        check("t2_prod_stall", {1'b0, bus.Stall}, 2'd0);
        cyc(1'b0, 1'b1, 3, 3, 4, 1'b1, 1'b0, 1'b0);
        check("t2_cons_stall",  {1'b0, bus.Stall},  FWD_EN ? 2'd0 : 2'd1);
        check("t2_cons_bubble", {1'b0, bus.Bubble}, FWD_EN ? 2'd0 : 2'd1);
`ifndef FORWARDING_EN
        cyc(1'b0, 1'b1, 3, 3, 4, 1'b1, 1'b0, 1'b0);
        check("t6_stall_2nd", {1'b0, bus.Stall}, 2'd1);
        cyc(1'b0, 1'b1, 3, 3, 4, 1'b1, 1'b0, 1'b0);
        check("t6_release", {1'b0, bus.Stall}, 2'd0);
`endif
        nop();
        check("t2_fwd_a", bus.FwdA_SEL, FWD_EN ? 2'd2 : 2'd0);
        check("t2_fwd_b", bus.FwdB_SEL, FWD_EN ? 2'd2 : 2'd0);

        // add r5 ; nop ; sub r6,r1,r5
        nop(); nop();
        cyc(1'b0, 1'b1, 1, 2, 5, 1'b1, 1'b0, 1'b0);
        nop();
        cyc(1'b0, 1'b1, 1, 5, 6, 1'b1, 1'b0, 1'b0);
        check("t3_stall", {1'b0, bus.Stall}, FWD_EN ? 2'd0 : 2'd1);
`ifndef FORWARDING_EN
        cyc(1'b0, 1'b1, 1, 5, 6, 1'b1, 1'b0, 1'b0);
        check("t3_release", {1'b0, bus.Stall}, 2'd0);
`endif
        nop();
        check("t3_fwd_a", bus.FwdA_SEL, 2'd0);
        check("t3_fwd_b", bus.FwdB_SEL, FWD_EN ? 2'd1 : 2'd0);

        // same with destination r0: never matches
        nop(); nop();
        cyc(1'b0, 1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b0);
        nop();
        cyc(1'b0, 1'b1, 1, 0, 6, 1'b1, 1'b0, 1'b0);
        check("t3_r0_stall", {1'b0, bus.Stall}, 2'd0);
        nop();
        check("t3_r0_fwd_b", bus.FwdB_SEL, 2'd0);

        // lw r7 ; add r8,r7,r2
        nop(); nop();
        cyc(1'b0, 1'b1, 1, 2, 7, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 7, 2, 8, 1'b1, 1'b0, 1'b0);
        check("t4_stall",  {1'b0, bus.Stall},  2'd1);
        check("t4_bubble", {1'b0, bus.Bubble}, 2'd1);
`ifndef FORWARDING_EN
        cyc(1'b0, 1'b1, 7, 2, 8, 1'b1, 1'b0, 1'b0);
        check("t4_stall_2nd", {1'b0, bus.Stall}, 2'd1);
`endif
        cyc(1'b0, 1'b1, 7, 2, 8, 1'b1, 1'b0, 1'b0);
        check("t4_release", {1'b0, bus.Stall}, 2'd0);
        nop();
        check("t4_fwd_a", bus.FwdA_SEL, FWD_EN ? 2'd1 : 2'd0);
        check("t4_fwd_b", bus.FwdB_SEL, 2'd0);

        // load-use hazard with Flush in the same cycle
        nop(); nop();
        cyc(1'b0, 1'b1, 1, 2, 7, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 7, 2, 8, 1'b1, 1'b0, 1'b1);
        check("t5_stall",  {1'b0, bus.Stall},  2'd0);
        check("t5_bubble", {1'b0, bus.Bubble}, 2'd1);
        nop();
        check("t5_fwd_a",  bus.FwdA_SEL, 2'd0);
        check("t5_fwd_b",  bus.FwdB_SEL, 2'd0);
        check("t5_run",    {1'b0, bus.Stall}, 2'd0);

        // reset held two cycles in the middle of a stall
        nop(); nop();
        cyc(1'b0, 1'b1, 1, 2, 3, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 3, 4, 9, 1'b1, 1'b0, 1'b0);
        check("t1_pre_stall", {1'b0, bus.Stall}, 2'd1);
        cyc(1'b1, 1'b1, 3, 4, 9, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 3, 4, 9, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 3, 4, 9, 1'b1, 1'b0, 1'b0);
        check("t1_stall",  {1'b0, bus.Stall},  2'd0);
        check("t1_bubble", {1'b0, bus.Bubble}, 2'd0);
        check("t1_fwd_a",  bus.FwdA_SEL, 2'd0);
        check("t1_fwd_b",  bus.FwdB_SEL, 2'd0);

        // randomized instruction stream on a small register set
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30,
                $urandom_range(0, 99) < 8);
        end
        nop();
        nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
